// File: rtl/ctrl_pkg.sv
// ctrl_pkg: states, opcode map, ALUOp codes and mux encodings shared by the multicycle controller.
package ctrl_pkg;
  typedef enum logic [3:0] {
    IDLE = 4'd0, FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE,
    EXEC_R, ALU_WB, EXEC_I, BRANCH, JUMP, TRAP
  } state_t;
  typedef enum logic [2:0] {CL_MEM, CL_R, CL_I, CL_BR, CL_J, CL_BAD} op_class_t;
  localparam logic [31:0] OP_R = 0, OP_J = 2, OP_JAL = 3, OP_BEQ = 4, OP_BNE = 5;
  localparam logic [31:0] OP_ADDI = 8, OP_SLTI = 10, OP_SLTIU = 11, OP_ANDI = 12;
  localparam logic [31:0] OP_ORI = 13, OP_XORI = 14, OP_LUI = 15, OP_LW = 35, OP_SW = 43;
  localparam logic [3:0] ALU_ADD = 1, ALU_AND = 2, ALU_OR = 3, ALU_XOR = 4, ALU_BEQ = 5;
  localparam logic [3:0] ALU_BNE = 6, ALU_SLT = 7, ALU_SLTU = 8, ALU_LUI = 9;
  localparam logic [3:0] ALU_LW = 10, ALU_SW = 11, ALU_RTYPE = 15;
  localparam logic       ADDR_PC = 1'b0, ADDR_ALUOUT = 1'b1;
  localparam logic [1:0] DST_RT = 2'd0, DST_RD = 2'd1, DST_RA = 2'd2;
  localparam logic [1:0] WB_ALU = 2'd0, WB_MDR = 2'd1, WB_PC = 2'd2;
  localparam logic       A_PC = 1'b0, A_RS = 1'b1;
  localparam logic [1:0] B_RT = 2'd0, B_4 = 2'd1, B_IMM = 2'd2, B_IMM_SH = 2'd3;
  localparam logic [1:0] PC_ALU = 2'd0, PC_ALUOUT = 2'd1, PC_JUMP = 2'd2;

  function automatic op_class_t op_class(input logic [31:0] op);
    case (op)
      OP_LW, OP_SW: return CL_MEM;
      OP_R: return CL_R;
      OP_ADDI, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: return CL_I;
      OP_BEQ, OP_BNE: return CL_BR;
      OP_J, OP_JAL: return CL_J;
      default: return CL_BAD;
    endcase
  endfunction

  function automatic logic [3:0] alu_i(input logic [31:0] op);
    return op == OP_ANDI ? ALU_AND : op == OP_ORI ? ALU_OR : op == OP_XORI ? ALU_XOR :
           op == OP_SLTI ? ALU_SLT : op == OP_SLTIU ? ALU_SLTU : op == OP_LUI ? ALU_LUI : ALU_ADD;
  endfunction
endpackage

// File: rtl/ctrl_out_decode.sv
// ctrl_out_decode: combinational (state, opcode) -> datapath controls; CTRL_ILLEGAL_TRAP_EN adds illegal_op.
module ctrl_out_decode
  import ctrl_pkg::*;
#(
  parameter int OPCODE_W = 6,
  parameter int ALUOP_W  = 4
) (
  input  state_t              st,
  input  logic [OPCODE_W-1:0] op,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                pc_write_cond,
  output logic                branch_ne,
  output logic                i_or_d,
  output logic                mem_read,
  output logic                mem_write,
  output logic                ir_write,
  output logic [1:0]          reg_dst,
  output logic [1:0]          mem_to_reg,
  output logic                reg_write,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [ALUOP_W-1:0]  alu_op,
`ifdef CTRL_ILLEGAL_TRAP_EN
  output logic                illegal_op,
`endif
  output logic [1:0]          pc_source,
  output logic                instr_done
);
  logic [31:0] o;
  assign o = 32'(op);
`ifdef CTRL_ILLEGAL_TRAP_EN
  assign illegal_op = st == TRAP;
`endif
  always_comb begin
    pc_write = 1'b0;
    pc_write_cond = 1'b0;
    branch_ne = 1'b0;
    i_or_d = ADDR_PC;
    mem_read = 1'b0;
    mem_write = 1'b0;
    ir_write = 1'b0;
    reg_dst = DST_RT;
    mem_to_reg = WB_ALU;
    reg_write = 1'b0;
    alu_src_a = A_PC;
    alu_src_b = B_RT;
    alu_op = '0;
    pc_source = PC_ALU;
    instr_done = 1'b0;
    case (st)
      FETCH: begin
        mem_read = 1'b1;
        ir_write = 1'b1;
        alu_src_b = B_4;
        alu_op = ALUOP_W'(ALU_ADD);
        pc_write = mem_ready;
      end
      DECODE: begin
        alu_src_b = B_IMM_SH;
        alu_op = ALUOP_W'(ALU_ADD);
`ifndef CTRL_ILLEGAL_TRAP_EN
        instr_done = op_class(o) == CL_BAD;
`endif
      end
      MEM_ADDR: begin
        alu_src_a = A_RS;
        alu_src_b = B_IMM;
        alu_op = ALUOP_W'(o == OP_SW ? ALU_SW : ALU_LW);
      end
      MEM_READ: begin
        mem_read = 1'b1;
        i_or_d = ADDR_ALUOUT;
      end
      MEM_WB: begin
        reg_write = 1'b1;
        mem_to_reg = WB_MDR;
        instr_done = 1'b1;
      end
      MEM_WRITE: begin
        mem_write = 1'b1;
        i_or_d = ADDR_ALUOUT;
        instr_done = mem_ready;
      end
      EXEC_R: begin
        alu_src_a = A_RS;
        alu_op = ALUOP_W'(ALU_RTYPE);
      end
      ALU_WB: begin
        reg_write = 1'b1;
        reg_dst = o == OP_R ? DST_RD : DST_RT;
        instr_done = 1'b1;
      end
      EXEC_I: begin
        alu_src_a = A_RS;
        alu_src_b = B_IMM;
        alu_op = ALUOP_W'(alu_i(o));
      end
      BRANCH: begin
        alu_src_a = A_RS;
        alu_op = ALUOP_W'(o == OP_BNE ? ALU_BNE : ALU_BEQ);
        pc_write_cond = 1'b1;
        pc_source = PC_ALUOUT;
        branch_ne = o == OP_BNE;
        instr_done = 1'b1;
      end
      JUMP: begin
        pc_write = 1'b1;
        pc_source = PC_JUMP;
        instr_done = 1'b1;
        reg_write = o == OP_JAL;
        reg_dst = o == OP_JAL ? DST_RA : DST_RT;
        mem_to_reg = o == OP_JAL ? WB_PC : WB_ALU;
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK sequencer for a shared-ALU, unified-memory datapath.
// Define CTRL_ILLEGAL_TRAP_EN to trap unknown opcodes (illegal_op port); otherwise they run as NOPs.
module multicycle_control
  import ctrl_pkg::*;
#(
  parameter int OPCODE_W = 6,
  parameter int ALUOP_W  = 4,
  parameter int STATE_W  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                pc_write_cond,
  output logic                branch_ne,
  output logic                i_or_d,
  output logic                mem_read,
  output logic                mem_write,
  output logic                ir_write,
  output logic [1:0]          reg_dst,
  output logic [1:0]          mem_to_reg,
  output logic                reg_write,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [ALUOP_W-1:0]  alu_op,
  output logic [1:0]          pc_source,
  output logic                instr_done,
`ifdef CTRL_ILLEGAL_TRAP_EN
  output logic                illegal_op,
`endif
  output logic [STATE_W-1:0]  state_o
);
  state_t              state;
  logic [OPCODE_W-1:0] op_q;
  logic                zero_unused;
  assign zero_unused = zero;
  assign state_o = STATE_W'(state);
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= IDLE;
      op_q <= '0;
    end else begin
      if (state == DECODE) op_q <= opcode;
      case (state)
        IDLE: state <= FETCH;
        FETCH: state <= mem_ready ? DECODE : FETCH;
        DECODE:
          case (op_class(32'(opcode)))
            CL_MEM: state <= MEM_ADDR;
            CL_R: state <= EXEC_R;
            CL_I: state <= EXEC_I;
            CL_BR: state <= BRANCH;
            CL_J: state <= JUMP;
`ifdef CTRL_ILLEGAL_TRAP_EN
            default: state <= TRAP;
`else
            default: state <= FETCH;
`endif
          endcase
        MEM_ADDR: state <= 32'(op_q) == OP_SW ? MEM_WRITE : MEM_READ;
        MEM_READ: state <= mem_ready ? MEM_WB : MEM_READ;
        MEM_WRITE: state <= mem_ready ? FETCH : MEM_WRITE;
        EXEC_R, EXEC_I: state <= ALU_WB;
        MEM_WB, ALU_WB, BRANCH, JUMP: state <= FETCH;
        TRAP: state <= TRAP;
        default: state <= IDLE;
      endcase
    end
  // In DECODE op_q is still the previous instruction, so decode the live opcode there.
  ctrl_out_decode #(.OPCODE_W(OPCODE_W), .ALUOP_W(ALUOP_W)) u_dec (
    .st(state),
    .op(state == DECODE ? opcode : op_q),
    .mem_ready(mem_ready),
    .pc_write(pc_write),
    .pc_write_cond(pc_write_cond),
    .branch_ne(branch_ne),
    .i_or_d(i_or_d),
    .mem_read(mem_read),
    .mem_write(mem_write),
    .ir_write(ir_write),
    .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg),
    .reg_write(reg_write),
    .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b),
    .alu_op(alu_op),
`ifdef CTRL_ILLEGAL_TRAP_EN
    .illegal_op(illegal_op),
`endif
    .pc_source(pc_source),
    .instr_done(instr_done)
  );
endmodule
